// File: rtl/tap_pkg.sv
// Shared definitions for the multi-channel TAP executor: instruction codes,
// command word layout and the per-channel configuration record.
package tap_pkg;

    typedef enum logic [3:0] {
        C_TAP_SET_GT      = 4'd0,
        C_TAP_SET_ET      = 4'd1,
        C_TAP_SET_LT      = 4'd2,
        C_TAP_SET_THR     = 4'd3,
        C_TAP_SET_TRIG_EN = 4'd4,
        C_TAP_SET_HOLDOFF = 4'd5,
        C_TAP_GET_MODE    = 4'd6,
        C_TAP_GET_THR     = 4'd7,
        C_TAP_GET_CNT     = 4'd8,
        C_TAP_CLR_CNT     = 4'd9
    } tap_instr_e;

    localparam int unsigned CMD_TGT_LSB   = 28;
    localparam int unsigned CMD_TGT_W     = 4;
    localparam int unsigned CMD_INSTR_LSB = 24;
    localparam int unsigned CMD_INSTR_W   = 4;
    localparam int unsigned CMD_CH_LSB    = 16;
    localparam int unsigned CMD_CH_W      = 8;
    localparam int unsigned CMD_DATA_LSB  = 0;
    localparam int unsigned CMD_DATA_W    = 16;

    localparam logic [CMD_CH_W-1:0] CH_BCAST = 8'hFF;

    // Fields are held at the maximum legal width; unused upper bits stay zero.
    typedef struct packed {
        logic        gt;
        logic        et;
        logic        lt;
        logic        trig_en;
        logic [15:0] thr;
        logic [15:0] holdoff;
    } tap_cfg_t;

endpackage

// File: rtl/tap_chan.sv
// One TAP channel: configuration registers, threshold comparator, hold-off
// counter and saturating trigger counter.
module tap_chan
    import tap_pkg::*;
#(
    parameter int unsigned THR_W  = 14,
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  tap_instr_e        wr_instr,
    input  logic [15:0]       wr_data,
    input  logic [THR_W-1:0]  sample,
    input  logic              sample_valid,
    output logic              trig,
    output logic [3:0]        mode_rd,
    output logic [15:0]       thr_rd,
    output logic [15:0]       cnt_rd
);

    localparam logic [15:0] THR_MASK  = 16'((32'd1 << THR_W) - 32'd1);
    localparam logic [15:0] HOLD_MASK = 16'((32'd1 << HOLD_W) - 32'd1);

    tap_cfg_t          cfg;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       s16;
    logic              hit;
    logic              fire;

    always_comb begin
        s16  = 16'(sample);
        hit  = sample_valid && cfg.trig_en &&
               ((cfg.gt && (s16 > cfg.thr)) ||
                (cfg.et && (s16 == cfg.thr)) ||
                (cfg.lt && (s16 < cfg.thr)));
        fire = hit && (hold_cnt == '0);
    end

    // Clear is applied after the trigger increment so it wins on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg      <= '0;
            hold_cnt <= '0;
            cnt      <= '0;
            trig     <= 1'b0;
        end else begin
            trig <= 1'b0;
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            if (fire) begin
                trig     <= 1'b1;
                hold_cnt <= HOLD_W'(cfg.holdoff);
                if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (wr_en) begin
                case (wr_instr)
                    C_TAP_SET_GT:      cfg.gt      <= wr_data[0];
                    C_TAP_SET_ET:      cfg.et      <= wr_data[0];
                    C_TAP_SET_LT:      cfg.lt      <= wr_data[0];
                    C_TAP_SET_TRIG_EN: cfg.trig_en <= wr_data[0];
                    C_TAP_SET_THR:     cfg.thr     <= wr_data & THR_MASK;
                    C_TAP_SET_HOLDOFF: cfg.holdoff <= wr_data & HOLD_MASK;
                    C_TAP_CLR_CNT:     cnt         <= '0;
                    default:           ;
                endcase
            end
        end
    end

    always_comb begin
        mode_rd = {cfg.trig_en, cfg.lt, cfg.et, cfg.gt};
        thr_rd  = cfg.thr;
        cnt_rd  = 16'(cnt);
    end

endmodule

// File: rtl/multi_tap_exe.sv
// Command executor for N_CH TAP channels: decode, error check, write fan-out,
// read-back and registered response, plus the per-channel trigger engines.
module multi_tap_exe
    import tap_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned THR_W  = 14,
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter logic [3:0]  TARGET = 4'h3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [31:0]           cmd,
    output logic [31:0]           rsp,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    input  logic [N_CH*THR_W-1:0] adc,
    input  logic                  adc_valid,
    output logic [N_CH-1:0]       trig
);

    logic [CMD_TGT_W-1:0]   tgt;
    logic [CMD_INSTR_W-1:0] instr_raw;
    tap_instr_e             instr;
    logic [CMD_CH_W-1:0]    ch;
    logic [CMD_DATA_W-1:0]  data;

    logic              accept;
    logic              bcast;
    logic              is_get;
    logic              err;
    logic              wr;
    logic [N_CH-1:0]   wr_en;

    logic [3:0]        mode_rd [N_CH];
    logic [15:0]       thr_rd  [N_CH];
    logic [15:0]       cnt_rd  [N_CH];
    logic [3:0]        mode_sel;
    logic [15:0]       thr_sel;
    logic [15:0]       cnt_sel;
    logic [15:0]       rd_data;

    always_comb begin
        tgt       = cmd[CMD_TGT_LSB   +: CMD_TGT_W];
        instr_raw = cmd[CMD_INSTR_LSB +: CMD_INSTR_W];
        instr     = tap_instr_e'(instr_raw);
        ch        = cmd[CMD_CH_LSB    +: CMD_CH_W];
        data      = cmd[CMD_DATA_LSB  +: CMD_DATA_W];

        accept = run && (tgt == TARGET);
        bcast  = (ch == CH_BCAST);
        is_get = (instr_raw >= 4'(C_TAP_GET_MODE)) && (instr_raw <= 4'(C_TAP_GET_CNT));
        err    = (instr_raw > 4'(C_TAP_CLR_CNT)) ||
                 (!bcast && (32'(ch) >= N_CH)) ||
                 (bcast && is_get);
        wr     = accept && !err && !is_get;

        for (int unsigned c = 0; c < N_CH; c++) begin
            wr_en[c] = wr && (bcast || (ch == 8'(c)));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        tap_chan #(
            .THR_W  (THR_W),
            .HOLD_W (HOLD_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (wr_en[g]),
            .wr_instr     (instr),
            .wr_data      (data),
            .sample       (adc[g*THR_W +: THR_W]),
            .sample_valid (adc_valid),
            .trig         (trig[g]),
            .mode_rd      (mode_rd[g]),
            .thr_rd       (thr_rd[g]),
            .cnt_rd       (cnt_rd[g])
        );
    end

    always_comb begin
        mode_sel = '0;
        thr_sel  = '0;
        cnt_sel  = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (ch == 8'(c)) begin
                mode_sel = mode_rd[c];
                thr_sel  = thr_rd[c];
                cnt_sel  = cnt_rd[c];
            end
        end

        rd_data = data;
        case (instr)
            C_TAP_GET_MODE: rd_data = {12'b0, mode_sel};
            C_TAP_GET_THR:  rd_data = thr_sel;
            C_TAP_GET_CNT:  rd_data = cnt_sel;
            default:        rd_data = data;
        endcase
    end

    // rsp and rsp_err hold between commands; only rsp_valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err <= err;
                rsp     <= err ? cmd : {cmd[31:16], rd_data};
            end
        end
    end

endmodule
